// File: rtl/delayed_io_capture_if.sv
// APB register-bus bundle shared by the delayed I/O blocks in the cmd_clk domain.
interface delayed_io_capture_if #(
    parameter int W_OFSET = 8
);
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [W_OFSET-1:0] paddr;
    logic [31:0]        pwdata;
    logic               pready;
    logic [31:0]        prdata;
    logic               pserr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pserr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pserr
    );
endinterface

// File: rtl/delayed_io_capture.sv
// Measures µs latency from an APB arm write to the first qualifying input edge, with timeout.
// Optional input stability filter: define DELAYED_IO_CAPTURE_GLITCH_FILTER_EN.
module delayed_io_capture #(
    parameter int CLK_FREQ   = 19541250,
    parameter int NUM_INPUTS = 4,
    parameter int W_OFSET    = 8
) (
    input  logic                  cmd_clk,
    input  logic                  cmd_rst_n,
    delayed_io_capture_if.slave   apb,
    input  logic [NUM_INPUTS-1:0] i_io_pins,
    output logic                  o_irq
);
    localparam int CYCLES_PER_US = (CLK_FREQ + 999999) / 1000000;
    localparam int PW = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CYCLES_PER_US - 1);
    localparam logic [7:0] LAT_BASE = 8'h40;

    typedef enum logic {ST_IDLE = 1'b0, ST_ARMED = 1'b1} state_e;

    function automatic logic [31:0] zext(input logic [NUM_INPUTS-1:0] v);
        zext = {{(32-NUM_INPUTS){1'b0}}, v};
    endfunction

    logic                  enable_r, rd_ready_r;
    logic [NUM_INPUTS-1:0] rise_en_r, fall_en_r, irq_mask_r, event_sts_r, timeout_sts_r;
    logic [31:0]           timeout_us_r, prdata_r, rd_data_s;
    logic [NUM_INPUTS-1:0] sync1_r, sync2_r, prev_r, level_s, qual_s, arm_s, armed_s;
    logic [NUM_INPUTS-1:0] ev_set_s, to_set_s, ev_clr_s, to_clr_s;
    logic [PW-1:0]         presc_r;
    logic [7:0]            addr_s;
    logic                  wr_s, rd_acc_s, tick_s, dis_s;
    logic                  wr_ctrl_s, wr_rise_s, wr_fall_s, wr_arm_s, wr_tmo_s, wr_evs_s, wr_tos_s, wr_msk_s;
    state_e                state_r     [NUM_INPUTS];
    state_e                state_nx    [NUM_INPUTS];
    logic [31:0]           elapsed_r   [NUM_INPUTS];
    logic [31:0]           elapsed_nx  [NUM_INPUTS];
    logic [31:0]           latency_r   [NUM_INPUTS];
    logic [31:0]           latency_nx  [NUM_INPUTS];

    assign addr_s   = apb.paddr[7:0];
    assign wr_s     = apb.psel & apb.penable & apb.pwrite;
    assign rd_acc_s = apb.psel & apb.penable & ~apb.pwrite & ~rd_ready_r;
    assign tick_s   = enable_r & (presc_r == PRESC_MAX);
    assign dis_s    = wr_ctrl_s & ~apb.pwdata[0];
    assign arm_s    = (wr_arm_s & enable_r) ? apb.pwdata[NUM_INPUTS-1:0] : {NUM_INPUTS{1'b0}};
    assign ev_clr_s = wr_evs_s ? apb.pwdata[NUM_INPUTS-1:0] : {NUM_INPUTS{1'b0}};
    assign to_clr_s = wr_tos_s ? apb.pwdata[NUM_INPUTS-1:0] : {NUM_INPUTS{1'b0}};
    assign qual_s   = (level_s & ~prev_r & rise_en_r) | (~level_s & prev_r & fall_en_r);

    assign apb.pready = wr_s | rd_ready_r;
    assign apb.prdata = prdata_r;
    assign apb.pserr  = 1'b0;
    assign o_irq      = |((event_sts_r | timeout_sts_r) & irq_mask_r);

    // Write-strobe decode
    always_comb begin
        {wr_ctrl_s, wr_rise_s, wr_fall_s, wr_arm_s, wr_tmo_s, wr_evs_s, wr_tos_s, wr_msk_s} = 8'h00;
        if (wr_s) begin
            case (addr_s)
                8'h00:   wr_ctrl_s = 1'b1;
                8'h04:   wr_rise_s = 1'b1;
                8'h08:   wr_fall_s = 1'b1;
                8'h0C:   wr_arm_s  = 1'b1;
                8'h10:   wr_tmo_s  = 1'b1;
                8'h14:   wr_evs_s  = 1'b1;
                8'h18:   wr_tos_s  = 1'b1;
                8'h24:   wr_msk_s  = 1'b1;
                default: wr_ctrl_s = 1'b0;
            endcase
        end else begin
            wr_ctrl_s = 1'b0;
        end
    end

    // Input synchroniser and edge-detect history
    always_ff @(posedge cmd_clk or negedge cmd_rst_n) begin
        if (!cmd_rst_n) begin
            sync1_r <= {NUM_INPUTS{1'b0}};
            sync2_r <= {NUM_INPUTS{1'b0}};
            prev_r  <= {NUM_INPUTS{1'b0}};
        end else begin
            sync1_r <= i_io_pins;
            sync2_r <= sync1_r;
            prev_r  <= level_s;
        end
    end

`ifdef DELAYED_IO_CAPTURE_GLITCH_FILTER_EN
    logic [3:0]            hist_r [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] filt_r;

    // Accept a new level only after four equal synchronised samples
    always_ff @(posedge cmd_clk or negedge cmd_rst_n) begin
        if (!cmd_rst_n) begin
            for (int i = 0; i < NUM_INPUTS; i++) hist_r[i] <= 4'h0;
            filt_r <= {NUM_INPUTS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                hist_r[i] <= {hist_r[i][2:0], sync2_r[i]};
                if (hist_r[i] == 4'hF)      filt_r[i] <= 1'b1;
                else if (hist_r[i] == 4'h0) filt_r[i] <= 1'b0;
                else                        filt_r[i] <= filt_r[i];
            end
        end
    end
    assign level_s = filt_r;
`else
    assign level_s = sync2_r;
`endif

    // Microsecond prescaler, parked at zero while disabled
    always_ff @(posedge cmd_clk or negedge cmd_rst_n) begin
        if (!cmd_rst_n)                 presc_r <= {PW{1'b0}};
        else if (!enable_r)             presc_r <= {PW{1'b0}};
        else if (presc_r == PRESC_MAX)  presc_r <= {PW{1'b0}};
        else                            presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
    end

    // Per-input FSM next state: disable > arm > edge > timeout > count
    always_comb begin
        ev_set_s = {NUM_INPUTS{1'b0}};
        to_set_s = {NUM_INPUTS{1'b0}};
        for (int i = 0; i < NUM_INPUTS; i++) begin
            state_nx[i]   = state_r[i];
            elapsed_nx[i] = elapsed_r[i];
            latency_nx[i] = latency_r[i];
            if (dis_s) begin
                state_nx[i] = ST_IDLE;
            end else if (arm_s[i]) begin
                state_nx[i]   = ST_ARMED;
                elapsed_nx[i] = 32'd0;
            end else if (state_r[i] == ST_ARMED) begin
                if (qual_s[i]) begin
                    state_nx[i]   = ST_IDLE;
                    latency_nx[i] = elapsed_r[i];
                    ev_set_s[i]   = 1'b1;
                end else if ((timeout_us_r != 32'd0) && (elapsed_r[i] == timeout_us_r)) begin
                    state_nx[i]   = ST_IDLE;
                    latency_nx[i] = timeout_us_r;
                    to_set_s[i]   = 1'b1;
                end else if (tick_s && (elapsed_r[i] != 32'hFFFF_FFFF)) begin
                    elapsed_nx[i] = elapsed_r[i] + 32'd1;
                end else begin
                    elapsed_nx[i] = elapsed_r[i];
                end
            end else begin
                state_nx[i] = ST_IDLE;
            end
        end
    end

    // Per-input FSM state, elapsed and latency registers
    always_ff @(posedge cmd_clk or negedge cmd_rst_n) begin
        if (!cmd_rst_n) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                state_r[i]   <= ST_IDLE;
                elapsed_r[i] <= 32'd0;
                latency_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                state_r[i]   <= state_nx[i];
                elapsed_r[i] <= elapsed_nx[i];
                latency_r[i] <= latency_nx[i];
            end
        end
    end

    // Configuration and status registers; hardware set wins over W1C
    always_ff @(posedge cmd_clk or negedge cmd_rst_n) begin
        if (!cmd_rst_n) begin
            enable_r      <= 1'b0;
            rise_en_r     <= {NUM_INPUTS{1'b0}};
            fall_en_r     <= {NUM_INPUTS{1'b0}};
            irq_mask_r    <= {NUM_INPUTS{1'b0}};
            timeout_us_r  <= 32'd1000;
            event_sts_r   <= {NUM_INPUTS{1'b0}};
            timeout_sts_r <= {NUM_INPUTS{1'b0}};
        end else begin
            if (wr_ctrl_s) enable_r     <= apb.pwdata[0];
            if (wr_rise_s) rise_en_r    <= apb.pwdata[NUM_INPUTS-1:0];
            if (wr_fall_s) fall_en_r    <= apb.pwdata[NUM_INPUTS-1:0];
            if (wr_msk_s)  irq_mask_r   <= apb.pwdata[NUM_INPUTS-1:0];
            if (wr_tmo_s)  timeout_us_r <= apb.pwdata;
            event_sts_r   <= (event_sts_r & ~ev_clr_s) | ev_set_s;
            timeout_sts_r <= (timeout_sts_r & ~to_clr_s) | to_set_s;
        end
    end

    // Read data mux
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) armed_s[i] = (state_r[i] == ST_ARMED);
        rd_data_s = 32'hBADA_DD12;
        case (addr_s)
            8'h00:   rd_data_s = {31'd0, enable_r};
            8'h04:   rd_data_s = zext(rise_en_r);
            8'h08:   rd_data_s = zext(fall_en_r);
            8'h0C:   rd_data_s = 32'd0;
            8'h10:   rd_data_s = timeout_us_r;
            8'h14:   rd_data_s = zext(event_sts_r);
            8'h18:   rd_data_s = zext(timeout_sts_r);
            8'h1C:   rd_data_s = zext(armed_s);
            8'h20:   rd_data_s = zext(level_s);
            8'h24:   rd_data_s = zext(irq_mask_r);
            8'hF8:   rd_data_s = 32'(CYCLES_PER_US);
            default: begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if (addr_s == LAT_BASE + 8'(4 * i)) rd_data_s = latency_r[i];
                end
            end
        endcase
    end

    // Registered read response: one extra access cycle per read
    always_ff @(posedge cmd_clk or negedge cmd_rst_n) begin
        if (!cmd_rst_n) begin
            rd_ready_r <= 1'b0;
            prdata_r   <= 32'd0;
        end else if (rd_ready_r) begin
            rd_ready_r <= 1'b0;
        end else if (rd_acc_s) begin
            rd_ready_r <= 1'b1;
            prdata_r   <= rd_data_s;
        end else begin
            rd_ready_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_delayed_io_capture.sv
// Directed bench for delayed_io_capture: APB reads checked against hand-computed values.
module tb_delayed_io_capture;
    logic       cmd_clk = 1'b0;
    logic       cmd_rst_n = 1'b0;
    logic [3:0] pins = 4'h0;
    logic       irq;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [31:0] rd, lat0;

`ifdef DELAYED_IO_CAPTURE_GLITCH_FILTER_EN
    localparam int          LEAD = 5;
    localparam logic [31:0] SHORT_PULSE_EV = 32'd0;
`else
    localparam int          LEAD = 0;
    localparam logic [31:0] SHORT_PULSE_EV = 32'd1;
`endif

    delayed_io_capture_if #(.W_OFSET(8)) apb_if ();

    delayed_io_capture #(.CLK_FREQ(19541250), .NUM_INPUTS(4), .W_OFSET(8)) dut (
        .cmd_clk   (cmd_clk),
        .cmd_rst_n (cmd_rst_n),
        .apb       (apb_if),
        .i_io_pins (pins),
        .o_irq     (irq)
    );

    always #5 cmd_clk = ~cmd_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                            output logic [31:0] rdat);
        int n;
        @(negedge cmd_clk);
        apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = wr;
        apb_if.paddr = a; apb_if.pwdata = wd;
        @(negedge cmd_clk);
        apb_if.penable = 1'b1;
        n = 0;
        #1;
        while (!apb_if.pready && n < 10) begin
            @(negedge cmd_clk); #1; n++;
        end
        if (!apb_if.pready) begin
            n_tests++; n_fail++;
            $error("FAIL apb_timeout: addr %h no pready after %0d cycles", a, n);
        end
        rdat = apb_if.prdata;
        @(posedge cmd_clk); #1;
        apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
    endtask

    task automatic wr32(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        apb_xfer(1'b1, a, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_xfer(1'b0, a, 32'd0, d);
        chk(tag, d, exp);
    endtask

    initial begin
        apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
        apb_if.paddr = 8'h00; apb_if.pwdata = 32'd0;
        repeat (3) @(negedge cmd_clk);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_pready", {31'd0, apb_if.pready}, 32'd0);
        chk("rst_prdata", apb_if.prdata, 32'd0);
        cmd_rst_n = 1'b1;
        repeat (2) @(negedge cmd_clk);
        rd_chk("rst_timeout", 8'h10, 32'd1000);
        rd_chk("rst_cpu", 8'hF8, 32'd20);
        rd_chk("rst_armed", 8'h1C, 32'd0);
        rd_chk("rst_ctrl", 8'h00, 32'd0);
        rd_chk("bad_addr", 8'h30, 32'hBADADD12);
        chk("pserr", {31'd0, apb_if.pserr}, 32'd0);

        // 500 us latency on pin0
        wr32(8'h00, 32'd1);
        wr32(8'h04, 32'd1);
        wr32(8'h0C, 32'd1);
        rd_chk("armed_bit0", 8'h1C, 32'd1);
        repeat (10000 - 4) @(negedge cmd_clk);
        pins[0] = 1'b1;
        repeat (10) @(negedge cmd_clk);
        apb_xfer(1'b0, 8'h40, 32'd0, lat0);
        chk("lat0_500_pm1", {31'd0, (lat0 == 32'd500) || (lat0 == 32'd501)}, 32'd1);
        rd_chk("event_sts", 8'h14, 32'd1);
        rd_chk("armed_after_ev", 8'h1C, 32'd0);
        rd_chk("level", 8'h20, 32'd1);
        wr32(8'h14, 32'd1);
        rd_chk("event_w1c", 8'h14, 32'd0);

        // 50 us timeout on pin1
        wr32(8'h10, 32'd50);
        wr32(8'h24, 32'd2);
        wr32(8'h0C, 32'd2);
        repeat (900) @(negedge cmd_clk);
        rd_chk("tmo_early", 8'h18, 32'd0);
        repeat (150) @(negedge cmd_clk);
        rd_chk("tmo_sts", 8'h18, 32'd2);
        rd_chk("tmo_lat1", 8'h44, 32'd50);
        chk("irq_set", {31'd0, irq}, 32'd1);
        wr32(8'h18, 32'd2);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        rd_chk("tmo_w1c", 8'h18, 32'd0);

        // Re-arm write lands in the same cycle the edge qualifies
        pins[0] = 1'b0;
        repeat (6) @(negedge cmd_clk);
        wr32(8'h0C, 32'd1);
        repeat (400) @(negedge cmd_clk);
        @(negedge cmd_clk);
        pins[0] = 1'b1;
        repeat (LEAD) @(negedge cmd_clk);
        wr32(8'h0C, 32'd1);
        rd_chk("sim_armed", 8'h1C, 32'd1);
        rd_chk("sim_no_ev", 8'h14, 32'd0);
        rd_chk("sim_lat_keep", 8'h40, lat0);
        repeat (900) @(negedge cmd_clk);
        rd_chk("sim_restart", 8'h18, 32'd0);
        repeat (150) @(negedge cmd_clk);
        rd_chk("sim_tmo", 8'h18, 32'd1);
        rd_chk("sim_tmo_lat", 8'h40, 32'd50);
        wr32(8'h18, 32'd1);

        // Edge while idle is ignored
        pins[0] = 1'b0;
        repeat (12) @(negedge cmd_clk);
        pins[0] = 1'b1;
        repeat (12) @(negedge cmd_clk);
        rd_chk("idle_edge", 8'h14, 32'd0);

        // Disable mid-measurement
        pins = 4'h0;
        wr32(8'h04, 32'hF);
        wr32(8'h08, 32'hF);
        repeat (12) @(negedge cmd_clk);
        wr32(8'h0C, 32'hF);
        rd_chk("arm_all", 8'h1C, 32'hF);
        wr32(8'h00, 32'd0);
        rd_chk("dis_armed", 8'h1C, 32'd0);
        pins = 4'hF;
        repeat (12) @(negedge cmd_clk);
        rd_chk("dis_ev", 8'h14, 32'd0);
        rd_chk("dis_tmo", 8'h18, 32'd0);
        rd_chk("dis_level", 8'h20, 32'hF);
        wr32(8'h0C, 32'hF);
        rd_chk("dis_arm_ign", 8'h1C, 32'd0);
        chk("dis_irq", {31'd0, irq}, 32'd0);

        // Short pulse: detected without the filter, rejected with it
        pins = 4'h0;
        wr32(8'h00, 32'd1);
        wr32(8'h04, 32'd1);
        wr32(8'h08, 32'd0);
        repeat (12) @(negedge cmd_clk);
        wr32(8'h0C, 32'd1);
        @(negedge cmd_clk);
        pins[0] = 1'b1;
        repeat (2) @(negedge cmd_clk);
        pins[0] = 1'b0;
        repeat (20) @(negedge cmd_clk);
        rd_chk("pulse2", 8'h14, SHORT_PULSE_EV);
`ifdef DELAYED_IO_CAPTURE_GLITCH_FILTER_EN
        pins[0] = 1'b1;
        repeat (10) @(negedge cmd_clk);
        pins[0] = 1'b0;
        repeat (20) @(negedge cmd_clk);
        rd_chk("pulse10", 8'h14, 32'd1);
`endif

        // Reset in the middle of a measurement
        wr32(8'h0C, 32'd1);
        repeat (100) @(negedge cmd_clk);
        cmd_rst_n = 1'b0;
        repeat (2) @(negedge cmd_clk);
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        cmd_rst_n = 1'b1;
        @(negedge cmd_clk);
        rd_chk("mid_rst_armed", 8'h1C, 32'd0);
        rd_chk("mid_rst_lat0", 8'h40, 32'd0);
        rd_chk("mid_rst_lat1", 8'h44, 32'd0);
        rd_chk("mid_rst_ev", 8'h14, 32'd0);
        rd_chk("mid_rst_tmo", 8'h10, 32'd1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
